wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_scoreboard.sv | 46 ++++
 rtl/wb_regfile.sv | 93 +++++++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback register file: control-vector
// bit positions, control width and the architectural register index type.
package wb_pkg;

    localparam int CTRL_W        = 18;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Busy scoreboard: one pending-write bit per register. A set and a clear on the
// same index in the same cycle leave the bit set, and register 0 is never busy.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en_i,
    input  reg_idx_t set_idx_i,
    input  logic     clr_en_i,
    input  reg_idx_t clr_idx_i,
    input  reg_idx_t rs_idx_i,
    input  reg_idx_t rt_idx_i,
    output logic     rs_busy_o,
    output logic     rt_busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // The clear is applied first so that a newer producer's set takes priority.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs_busy_o = busy_q[rs_idx_i];
    assign rt_busy_o = busy_q[rt_idx_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file with two combinational read ports, a busy
// scoreboard and a one-cycle commit pulse. Optional macro: REGFILE_BYPASS_EN.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] wb_ctrl,
    input  reg_idx_t          wb_rd,
    input  logic [XLEN-1:0]   wb_alu_result,
    input  logic [XLEN-1:0]   wb_mem_data,
    input  reg_idx_t          rs_addr,
    input  reg_idx_t          rt_addr,
    output logic [XLEN-1:0]   rs_data,
    output logic [XLEN-1:0]   rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              issue_en,
    input  reg_idx_t          issue_rd,
    output logic              wb_commit
);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic            commit_q;
    logic            wr_en;
    logic [XLEN-1:0] wr_data;
    logic            sb_rs_busy;
    logic            sb_rt_busy;
    logic            byp_rs;
    logic            byp_rt;
    logic            unused_ctrl;

    assign wr_en       = wb_ctrl[CTRL_REGWRITE] && (wb_rd != '0);
    assign wr_data     = wb_ctrl[CTRL_MEMTOREG] ? wb_mem_data : wb_alu_result;
    assign unused_ctrl = ^wb_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            commit_q <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[wb_rd] <= wr_data;
            end
            commit_q <= wr_en;
        end
    end

    wb_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (issue_en && (issue_rd != '0)),
        .set_idx_i (issue_rd),
        .clr_en_i  (wr_en),
        .clr_idx_i (wb_rd),
        .rs_idx_i  (rs_addr),
        .rt_idx_i  (rt_addr),
        .rs_busy_o (sb_rs_busy),
        .rt_busy_o (sb_rt_busy)
    );

`ifdef REGFILE_BYPASS_EN
    // Gated by reset so nothing leaks onto the read ports while held in reset.
    assign byp_rs = reset && wr_en && (rs_addr == wb_rd);
    assign byp_rt = reset && wr_en && (rt_addr == wb_rd);
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = byp_rs ? wr_data : regs_q[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = byp_rt ? wr_data : regs_q[rt_addr];
        end
    end

    assign rs_busy   = sb_rs_busy && !byp_rs;
    assign rt_busy   = sb_rt_busy && !byp_rt;
    assign wb_commit = commit_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed per-cycle vectors push expected outputs into a
// queue; a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [17:0] wb_ctrl;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_busy;
  logic        rt_busy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wb_commit;

  int checks;
  int failures;

  // Expected entry layout: {rs_data, rt_data, rs_busy, rt_busy, wb_commit}.
  logic [66:0] exp_q[$];
  int          id_q[$];

  wb_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .wb_ctrl       (wb_ctrl),
    .wb_rd         (wb_rd),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .wb_commit     (wb_commit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [66:0] e;
      int          id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      chk($sformatf("v%0d.rs_data", id), rs_data, e[66:35]);
      chk($sformatf("v%0d.rt_data", id), rt_data, e[34:3]);
      chk($sformatf("v%0d.rs_busy", id), {31'b0, rs_busy}, {31'b0, e[2]});
      chk($sformatf("v%0d.rt_busy", id), {31'b0, rt_busy}, {31'b0, e[1]});
      chk($sformatf("v%0d.commit", id), {31'b0, wb_commit}, {31'b0, e[0]});
    end
  end

  task automatic idle_inputs();
    wb_ctrl = '0; wb_rd = '0; wb_alu_result = '0; wb_mem_data = '0;
    rs_addr = '0; rt_addr = '0; issue_en = 1'b0; issue_rd = '0;
  endtask

  // driver: apply one cycle of inputs and queue the outputs expected that cycle
  task automatic vec(input int id, input logic [4:0] rs_a, input logic [4:0] rt_a,
                     input logic [17:0] ctrl, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] mem,
                     input logic ie, input logic [4:0] ird,
                     input logic [31:0] ers, input logic [31:0] ert,
                     input logic erb, input logic etb, input logic ec);
    @(posedge clk);
    #1;
    rs_addr = rs_a; rt_addr = rt_a; wb_ctrl = ctrl; wb_rd = rd;
    wb_alu_result = alu; wb_mem_data = mem; issue_en = ie; issue_rd = ird;
    exp_q.push_back({ers, ert, erb, etb, ec});
    id_q.push_back(id);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    reset = 1'b0;
    rt_addr = 5'd5;
    #1;
    chk("por.rt_data", rt_data, 32'h0);
    chk("por.commit", {31'b0, wb_commit}, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    //   id rs  rt  ctrl       rd   alu           mem           ie  ird  exp_rs                           exp_rt                         rsb              rtb              commit
    vec(0,  0,  5,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(1,  5,  0,  18'h1,     5,  32'hDEADBEEF, 32'h0,        0,  0,   BYP ? 32'hDEADBEEF : 32'h0,      32'h0,                         0,               0,               0);
    vec(2,  5,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'hDEADBEEF,                    32'h0,                         0,               0,               1);
    vec(3,  5,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'hDEADBEEF,                    32'h0,                         0,               0,               0);
    vec(4,  0,  0,  18'h3,     0,  32'h0,        32'h12345678, 0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(5,  0,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(6,  7,  0,  18'h0,     0,  32'h0,        32'h0,        1,  7,   32'h0,                           32'h0,                         0,               0,               0);
    vec(7,  7,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'h0,                         1,               0,               0);
    vec(8,  7,  0,  18'h1,     7,  32'h77,       32'h0,        0,  0,   BYP ? 32'h77 : 32'h0,            32'h0,                         !BYP,            0,               0);
    vec(9,  7,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h77,                          32'h0,                         0,               0,               1);
    vec(10, 9,  0,  18'h1,     9,  32'h99,       32'h0,        1,  9,   BYP ? 32'h99 : 32'h0,            32'h0,                         0,               0,               0);
    vec(11, 9,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h99,                          32'h0,                         1,               0,               1);
    vec(12, 9,  10, 18'h3,     9,  32'h0,        32'hAAAA,     1,  10,  BYP ? 32'hAAAA : 32'h99,         32'h0,                         !BYP,            0,               0);
    vec(13, 9,  10, 18'h0,     0,  32'h0,        32'h0,        0,  0,   32'hAAAA,                        32'h0,                         0,               1,               1);
    vec(14, 0,  3,  18'h3FFFD, 3,  32'h11111111, 32'hBAD,      0,  0,   32'h0,                           BYP ? 32'h11111111 : 32'h0,    0,               0,               0);
    vec(15, 0,  3,  18'h1,     3,  32'hA5A5A5A5, 32'h0,        0,  0,   32'h0,                           BYP ? 32'hA5A5A5A5 : 32'h11111111, 0,          0,               1);
    vec(16, 0,  3,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'hA5A5A5A5,                  0,               0,               1);
    vec(17, 0,  4,  18'h3FFFE, 4,  32'hBAD,      32'hBAD,      0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(18, 0,  4,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(19, 0,  0,  18'h0,     0,  32'h0,        32'h0,        1,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(20, 0,  0,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(21, 12, 0,  18'h0,     0,  32'h0,        32'h0,        1,  12,  32'h0,                           32'h0,                         0,               0,               0);
    vec(22, 12, 6,  18'h1,     6,  32'h66,       32'h0,        0,  0,   32'h0,                           BYP ? 32'h66 : 32'h0,          1,               0,               0);

    // mid-run asynchronous reset while a commit pulse is high
    @(posedge clk);
    #2;
    idle_inputs();
    rs_addr = 5'd12; rt_addr = 5'd5;
    #1;
    chk("pre_rst.commit", {31'b0, wb_commit}, 32'h1);
    chk("pre_rst.rt_data", rt_data, 32'hDEADBEEF);
    reset = 1'b0;
    #1;
    chk("rst.rs_data", rs_data, 32'h0);
    chk("rst.rt_data", rt_data, 32'h0);
    chk("rst.rs_busy", {31'b0, rs_busy}, 32'h0);
    chk("rst.commit", {31'b0, wb_commit}, 32'h0);
    wb_ctrl = 18'h1; wb_rd = 5'd5; wb_alu_result = 32'hFFFF; issue_en = 1'b1; issue_rd = 5'd13;
    rs_addr = 5'd13;
    #1;
    chk("rst_hold.rt_data_same_cycle", rt_data, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold.rt_data", rt_data, 32'h0);
    chk("rst_hold.rs_busy", {31'b0, rs_busy}, 32'h0);
    chk("rst_hold.commit", {31'b0, wb_commit}, 32'h0);
    #2;
    idle_inputs();
    reset = 1'b1;

    vec(23, 12, 5,  18'h0,     0,  32'h0,        32'h0,        0,  0,   32'h0,                           32'h0,                         0,               0,               0);
    vec(24, 5,  13, 18'h1,     5,  32'hCAFE,     32'h0,        0,  0,   BYP ? 32'hCAFE : 32'h0,          32'h0,                         0,               0,               0);
    vec(25, 5,  13, 18'h0,     0,  32'h0,        32'h0,        0,  0,   32'hCAFE,                        32'h0,                         0,               0,               1);
    @(posedge clk);
    #1;
    idle_inputs();

    begin
      int budget;
      budget = 5;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
